mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data memory between the rv32i_pipeline

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_wait_timer.sv | 35 +++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state encodings
// and the full-word byte-enable pattern used for fetches and loads.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arbState_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Only stores drive partial byte enables; everything else reads a full word.
    function automatic logic [3:0] accessBe(input logic we, input logic [3:0] be);
        return we ? be : BE_WORD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-state watchdog: counts cycles spent waiting on the memory and raises a
// sticky error once the limit is hit. A TIMEOUT of 0 disables the watchdog.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic err
);

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit            ENABLED = (TIMEOUT > 0);
    localparam logic [CW-1:0] LIMIT   = ENABLED ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // The count stops at LIMIT so it never wraps while the memory stays stuck.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && ENABLED) begin
            if (count == LIMIT) begin
                err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// data stage, registering every memory-side signal and the returned read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    arbState_t state;
    logic      dPending;
    logic      ifPending;

    // A requester still holds req during its valid pulse, so that cycle is not a new request.
    assign dPending  = d_req && !d_valid;
    assign ifPending = if_req && !if_flush && !if_valid;

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dPending) begin
                        state     <= ST_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= accessBe(d_we, d_be);
                        mem_addr  <= d_addr;
                        mem_wdata <= d_we ? d_wdata : '0;
                    end else if (ifPending) begin
                        state     <= ST_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= BE_WORD;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        if (!if_flush) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (if_flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DATA: begin
                    if (mem_ready) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_valid <= 1'b1;
                        d_rdata <= mem_we ? '0 : mem_rdata;
                    end
                end
                // The memory cannot be aborted, so a cancelled fetch is waited out silently.
                ST_DRAIN: begin
                    if (mem_ready) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) waitTimer (
        .clk   (clk),
        .reset (reset),
        .enable(mem_req && !mem_ready),
        .clear (mem_ready),
        .err   (err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory with programmable
// wait states, a table of single accesses, and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural memory: ready after waitTarget wait cycles, unless stuck.
    logic [31:0] memImg [0:255];
    logic [31:0] refMem [0:255];
    int waitCnt = 0, waitTarget = 0, waitStates = 0;
    bit randWaits = 1'b0, stuck = 1'b0;

    function automatic logic [31:0] imgWord(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h01000101;
    endfunction

    assign mem_ready = mem_req && !stuck && (waitCnt == waitTarget);
    assign mem_rdata = memImg[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) memImg[i] <= imgWord(i);
        end else if (mem_req && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) memImg[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (!mem_req || mem_ready) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
        if (!mem_req) waitTarget <= randWaits ? int'($urandom_range(0, 3)) : waitStates;
    end

    logic [31:0] ifExpQ[$];
    logic [31:0] dExpQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard: every valid pulse pops the expectation pushed when its request was issued.
    always @(negedge clk) begin
        if (if_valid) begin
            if (ifExpQ.size() == 0) checkOutput("ifValidUnexpected", {31'b0, if_valid}, 32'h0);
            else checkOutput("ifRdata", if_rdata, ifExpQ.pop_front());
        end
        if (d_valid) begin
            if (dExpQ.size() == 0) checkOutput("dValidUnexpected", {31'b0, d_valid}, 32'h0);
            else checkOutput("dRdata", d_rdata, dExpQ.pop_front());
        end
    end

    function automatic void initRef();
        for (int i = 0; i < 256; i++) refMem[i] = imgWord(i);
    endfunction

    task automatic issueFetch(input logic [31:0] addr, input bit pushExp);
        if_addr = addr;
        if_req  = 1'b1;
        if (pushExp) ifExpQ.push_back(refMem[addr[9:2]]);
    endtask

    task automatic issueData(input bit we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit pushExp);
        d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        if (pushExp) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
                dExpQ.push_back(32'h0);
            end else begin
                dExpQ.push_back(refMem[addr[9:2]]);
            end
        end
    endtask

    task automatic waitValid(input bit isData, output int cycles, output logic [3:0] seenBe,
                             output logic [31:0] seenAddr, output logic [31:0] seenWdata,
                             output int weCycles);
        cycles = 0; weCycles = 0; seenBe = 4'h0; seenAddr = 32'h0; seenWdata = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cycles++;
            if (mem_req) begin
                seenBe = mem_be; seenAddr = mem_addr; seenWdata = mem_wdata;
                if (mem_we) weCycles++;
            end
            if (isData ? d_valid : if_valid) begin
                if (isData) d_req = 1'b0;
                else if_req = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: no valid after %0d cycles, required within 60", isData ? "dTimeout" : "ifTimeout", cycles);
        if (isData) d_req = 1'b0;
        else if_req = 1'b0;
    endtask

    typedef struct {
        bit          isData;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          expLatency;
        logic [3:0]  expBe;
        int          expWeCycles;
    } vec_t;

    vec_t vecs[8];

    task automatic applyStimulus(input vec_t v);
        waitStates = v.waits;
        if (v.isData) issueData(v.we, v.be, v.addr, v.wdata, 1'b1);
        else issueFetch(v.addr, 1'b1);
    endtask

    initial begin
        int lat, weC, grants, dCyc, ifCyc;
        logic [3:0] be;
        logic [31:0] addr, wd, firstAddr, secondAddr;
        logic [3:0] reqTrace;
        logic prevReq;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0004, 32'h0,         0, 2, 4'hF, 0};
        vecs[1] = '{1'b0, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         1, 3, 4'hF, 0};
        vecs[2] = '{1'b1, 1'b0, 4'h1, 32'h0000_0100, 32'h0,         0, 2, 4'hF, 0};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0104, 32'hDEADBEEF,  3, 5, 4'h3, 4};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         2, 4, 4'hF, 0};
        vecs[5] = '{1'b1, 1'b1, 4'hC, 32'h0000_0108, 32'h12345678,  0, 2, 4'hC, 1};
        vecs[6] = '{1'b1, 1'b0, 4'h0, 32'h0000_0108, 32'h0,         0, 2, 4'hF, 0};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h0000_007C, 32'h0,         2, 4, 4'hF, 0};

        reset = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        initRef();
        repeat (3) @(negedge clk);
        checkOutput("resetMemReq",  {31'b0, mem_req},  32'h0);
        checkOutput("resetIfValid", {31'b0, if_valid}, 32'h0);
        checkOutput("resetDValid",  {31'b0, d_valid},  32'h0);
        checkOutput("resetErr",     {31'b0, err},      32'h0);
        checkOutput("resetMemAddr", mem_addr,          32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            waitValid(vecs[i].isData, lat, be, addr, wd, weC);
            checkOutput($sformatf("vec%0dLatency", i), lat, vecs[i].expLatency);
            checkOutput($sformatf("vec%0dMemBe", i), {28'b0, be}, {28'b0, vecs[i].expBe});
            checkOutput($sformatf("vec%0dMemAddr", i), addr, vecs[i].addr);
            checkOutput($sformatf("vec%0dWeCycles", i), weC, vecs[i].expWeCycles);
            if (vecs[i].we) checkOutput($sformatf("vec%0dMemWdata", i), wd, vecs[i].wdata);
        end

        // Simultaneous requests: data first, one idle cycle, then the fetch.
        @(negedge clk);
        waitStates = 0;
        issueFetch(32'h10, 1'b1);
        issueData(1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
        #1;
        checkOutput("bothStallIf", {31'b0, if_stall}, 32'h1);
        checkOutput("bothStallD",  {31'b0, d_stall},  32'h1);
        grants = 0; dCyc = 0; ifCyc = 0; prevReq = 1'b0; reqTrace = 4'h0;
        firstAddr = 32'h0; secondAddr = 32'h0;
        for (int c = 1; c <= 20 && (dCyc == 0 || ifCyc == 0); c++) begin
            @(negedge clk);
            if (c <= 4) reqTrace[c-1] = mem_req;
            if (mem_req && !prevReq) begin
                grants++;
                if (grants == 1) firstAddr = mem_addr;
                if (grants == 2) secondAddr = mem_addr;
            end
            prevReq = mem_req;
            if (d_valid)  begin dCyc = c;  d_req = 1'b0;  end
            if (if_valid) begin ifCyc = c; if_req = 1'b0; end
        end
        checkOutput("orderGrants",     grants,     2);
        checkOutput("orderFirstAddr",  firstAddr,  32'h100);
        checkOutput("orderSecondAddr", secondAddr, 32'h10);
        checkOutput("orderDValidCyc",  dCyc,       2);
        checkOutput("orderIfValidCyc", ifCyc,      4);
        checkOutput("orderReqTrace",   {28'b0, reqTrace}, 32'h5);

        // Flush one cycle after the fetch grant, with two wait states: drained silently.
        @(negedge clk);
        waitStates = 2;
        issueFetch(32'h20, 1'b0);
        @(negedge clk);
        checkOutput("drainGranted", {31'b0, mem_req}, 32'h1);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0; if_req = 1'b0;
        checkOutput("drainHoldReq1", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        checkOutput("drainHoldReq2", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        checkOutput("drainReqDrop", {31'b0, mem_req},  32'h0);
        checkOutput("drainNoValid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        waitStates = 0;
        issueFetch(32'h24, 1'b1);
        waitValid(1'b0, lat, be, addr, wd, weC);
        checkOutput("drainThenIdleLat", lat, 2);

        // Flush in the same cycle as mem_ready: the response is dropped.
        @(negedge clk);
        waitStates = 1;
        issueFetch(32'h28, 1'b0);
        repeat (2) @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0; if_req = 1'b0;
        checkOutput("flushAtReadyReq",   {31'b0, mem_req},  32'h0);
        checkOutput("flushAtReadyValid", {31'b0, if_valid}, 32'h0);

        // Flush in IDLE delays the fetch grant by exactly one cycle.
        @(negedge clk);
        waitStates = 0;
        issueFetch(32'h2C, 1'b1);
        if_flush = 1'b1;
        @(negedge clk);
        checkOutput("idleFlushBlocks", {31'b0, mem_req}, 32'h0);
        if_flush = 1'b0;
        waitValid(1'b0, lat, be, addr, wd, weC);
        checkOutput("idleFlushLat", lat, 2);

        // Stuck memory: err after the 16th wait cycle, then a reset clears everything.
        @(negedge clk);
        stuck = 1'b1;
        issueData(1'b0, 4'hF, 32'h10C, 32'h0, 1'b0);
        repeat (16) @(negedge clk);
        checkOutput("timeoutErrEarly", {31'b0, err}, 32'h0);
        @(negedge clk);
        checkOutput("timeoutErrSet",   {31'b0, err},     32'h1);
        checkOutput("timeoutStillReq", {31'b0, mem_req}, 32'h1);
        reset = 1'b0; d_req = 1'b0; stuck = 1'b0;
        @(negedge clk);
        checkOutput("midResetMemReq", {31'b0, mem_req}, 32'h0);
        checkOutput("midResetErr",    {31'b0, err},     32'h0);
        checkOutput("midResetMemBe",  {28'b0, mem_be},  32'h0);
        checkOutput("midResetDRdata", d_rdata,          32'h0);
        checkOutput("midResetIfRdata", if_rdata,        32'h0);
        reset = 1'b1;
        initRef();
        dExpQ.delete();
        @(negedge clk);

        // Mixed concurrent traffic with random wait states against the reference image.
        randWaits = 1'b1;
        fork
            begin : fetchProc
                int fLat, fWe;
                logic [3:0] fBe;
                logic [31:0] fAddr, fWd;
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    issueFetch({25'b0, 5'($urandom_range(0, 31)), 2'b00}, 1'b1);
                    waitValid(1'b0, fLat, fBe, fAddr, fWd, fWe);
                end
            end
            begin : dataProc
                int xLat, xWe;
                logic [3:0] xBe;
                logic [31:0] xAddr, xWd;
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    issueData(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                              32'h100 + {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 1'b1);
                    waitValid(1'b1, xLat, xBe, xAddr, xWd, xWe);
                end
            end
        join
        randWaits = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("ifQueueDrained", ifExpQ.size(), 32'h0);
        checkOutput("dQueueDrained",  dExpQ.size(),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
